// File: rtl/logic_diag10.sv
// Registered four-input Boolean evaluator: o = TRUTH_TABLE[{a,b,c,d}], one cycle late.
// The output comes straight from a flop, so it is glitch-free and defined by reset.
module logic_diag10 #(
   parameter logic [15:0] TRUTH_TABLE = 16'hF222
) (
   input  logic clk,
   input  logic rst_n,
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic d,
   output logic o
);

   logic [3:0] idx;
   logic       o_d;
   logic       o_q;

   // A parameter lookup covers every TRUTH_TABLE value with the same structure;
   // synthesis folds the constant table into the minimal sum-of-products.
   assign idx = {a, b, c, d};
   assign o_d = TRUTH_TABLE[idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignment keeps flop updates order-independent across processes.
         o_q <= o_d;
      end
   end

   assign o = o_q;

endmodule

// File: tb/tb_logic_diag10.sv
// Self-checking bench for logic_diag10: directed scenarios plus random stimulus
// compared against Boolean-formula reference models.
module tb_logic_diag10;

   logic clk;
   logic rst_n;
   logic a, b, c, d;
   logic o;
   logic o_ovr;

   int pass_cnt;
   int total_cnt;

   logic_diag10 u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .c     (c),
      .d     (d),
      .o     (o)
   );

   logic_diag10 #(.TRUTH_TABLE(16'h8000)) u_ovr (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .c     (c),
      .d     (d),
      .o     (o_ovr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Default function: o = (a AND b) OR (NOT c AND d).
   function automatic logic model_def(input logic [3:0] i);
      logic ma, mb, mc, md;
      {ma, mb, mc, md} = i;
      return (ma & mb) | (~mc & md);
   endfunction

   // Override 16'h8000: o = a AND b AND c AND d.
   function automatic logic model_ovr(input logic [3:0] i);
      return i == 4'd15;
   endfunction

   task automatic drive(input logic [3:0] i);
      {a, b, c, d} = i;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(4'hF);
      #1;
      total_cnt++;
      if (o !== 1'b0) $display("FAIL reset_initial: o=%b expected 0", o);
      else pass_cnt++;
      for (int k = 0; k < 4; k++) begin
         step();
         total_cnt++;
         if (o !== 1'b0 || o_ovr !== 1'b0)
            $display("FAIL reset_hold[%0d]: o=%b o_ovr=%b expected 0/0", k, o, o_ovr);
         else pass_cnt++;
      end
      #2 rst_n = 1'b1;
      #1;
      total_cnt++;
      if (o !== 1'b0) $display("FAIL reset_release_no_edge: o=%b expected 0", o);
      else pass_cnt++;
      step();
      total_cnt++;
      if (o !== 1'b1 || o_ovr !== 1'b1)
         $display("FAIL reset_first_edge: o=%b o_ovr=%b expected 1/1", o, o_ovr);
      else pass_cnt++;
   endtask

   task automatic test_sweep();
      logic [15:0] seq;
      seq = 16'b1111_0010_0010_0010; // bit i = expected o for index i
      for (int i = 0; i < 16; i++) begin
         drive(4'(i));
         step();
         total_cnt++;
         if (o !== model_def(4'(i)) || o !== seq[i])
            $display("FAIL sweep[%0d]: o=%b expected %b", i, o, seq[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_latency();
      drive(4'd0);
      step();
      total_cnt++;
      if (o !== 1'b0) $display("FAIL latency_pre: o=%b expected 0", o);
      else pass_cnt++;
      #1 drive(4'd12);
      #1 drive(4'd3);
      #1 drive(4'd1);
      #1;
      total_cnt++;
      if (o !== 1'b0) $display("FAIL latency_between_edges: o=%b expected 0", o);
      else pass_cnt++;
      step();
      total_cnt++;
      if (o !== 1'b1) $display("FAIL latency_after_edge: o=%b expected 1", o);
      else pass_cnt++;
   endtask

   task automatic test_terms();
      drive(4'b1110);
      step();
      total_cnt++;
      if (o !== 1'b1) $display("FAIL term_and_only: o=%b expected 1", o);
      else pass_cnt++;
      drive(4'b0111);
      step();
      total_cnt++;
      if (o !== 1'b0) $display("FAIL term_none: o=%b expected 0", o);
      else pass_cnt++;
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i <= 13; i++) begin
         drive(4'(i));
         step();
      end
      total_cnt++;
      if (o !== 1'b1) $display("FAIL mid_reset_before: o=%b expected 1", o);
      else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      total_cnt++;
      if (o !== 1'b0) $display("FAIL mid_reset_async: o=%b expected 0", o);
      else pass_cnt++;
      #1 rst_n = 1'b1;
      #1;
      total_cnt++;
      if (o !== 1'b0) $display("FAIL mid_reset_released: o=%b expected 0", o);
      else pass_cnt++;
      step();
      total_cnt++;
      if (o !== 1'b1) $display("FAIL mid_reset_restore: o=%b expected 1", o);
      else pass_cnt++;
      // Reset asserted on the same instant as a rising edge must win.
      drive(4'd15);
      @(posedge clk);
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if (o !== 1'b0 || o_ovr !== 1'b0)
         $display("FAIL reset_at_edge: o=%b o_ovr=%b expected 0/0", o, o_ovr);
      else pass_cnt++;
      #3 rst_n = 1'b1;
      step();
      total_cnt++;
      if (o !== 1'b1) $display("FAIL reset_at_edge_recover: o=%b expected 1", o);
      else pass_cnt++;
   endtask

   task automatic test_override();
      for (int i = 0; i < 16; i++) begin
         drive(4'(i));
         step();
         total_cnt++;
         if (o_ovr !== model_ovr(4'(i)))
            $display("FAIL override[%0d]: o_ovr=%b expected %b", i, o_ovr, model_ovr(4'(i)));
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] r;
      for (int k = 0; k < 200; k++) begin
         r = 4'($urandom_range(0, 15));
         drive(r);
         step();
         total_cnt++;
         if (o !== model_def(r) || o_ovr !== model_ovr(r))
            $display("FAIL random[%0d] idx=%0d: o=%b o_ovr=%b expected %b/%b",
                     k, r, o, o_ovr, model_def(r), model_ovr(r));
         else pass_cnt++;
      end
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      rst_n     = 1'b0;
      drive(4'd0);
      test_reset();
      test_sweep();
      test_latency();
      test_terms();
      test_mid_reset();
      test_override();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/logic_diag10.md
# logic_diag10

Registered four-input combinational logic evaluator. It implements a fixed sum-of-products function of inputs `a`, `b`, `c`, `d` and presents the result on `o`, registered on one clock. It is a leaf cell used wherever the diagram-10 Boolean function is needed with a clean, glitch-free, reset-defined output.

## Interface
- `TRUTH_TABLE`, default `16'hF222`: 16-entry truth table. Bit `i` is the value of `o` for input index `i = {a,b,c,d}` (`a` is the MSB). The default encodes `o = (a AND b) OR (NOT c AND d)`.
- `clk`, input, 1 bit: single clock; all state changes occur on the rising edge.
- `rst_n`, input, 1 bit: asynchronous, active-low reset.
- `a`, input, 1 bit: function input, index bit 3.
- `b`, input, 1 bit: function input, index bit 2.
- `c`, input, 1 bit: function input, index bit 1.
- `d`, input, 1 bit: function input, index bit 0.
- `o`, output, 1 bit: registered function result.

## Operation
- Form the index `idx = {a,b,c,d}`, a 4-bit unsigned value in the range 0 to 15.
- Next-state value is `f = TRUTH_TABLE[idx]`. All 16 indices are defined, so no input combination is a don't-care.
- With the default parameter, `o` is 1 for indices 1, 5, 9, 12, 13, 14 and 15, and 0 for all other indices.
- The implementation may use a gate-level sum-of-products or a parameter lookup. Both must yield an identical result for every `TRUTH_TABLE` value.
- `o` is driven only from a flip-flop. There is no combinational path from the inputs to `o`.
- X or Z on any input propagates as X into `o` at the next edge. This is not a defined operating condition.

## Timing
- Reset:
  - `rst_n` low forces `o` to 0 immediately, without waiting for `clk`.
  - `o` holds at 0 for as long as `rst_n` is low, regardless of the inputs.
- Reset release:
  - `rst_n` rising has no effect by itself.
  - The first rising `clk` edge with `rst_n` high loads `f`.
- Latency:
  - One cycle. Inputs sampled at rising edge N appear on `o` just after edge N.
  - `o` is then stable until edge N+1.
- Inputs must meet setup and hold around the rising edge. Inputs may change any number of times between edges; only the value at the edge matters.
- Simultaneous events:
  - Reset asserted in the same instant as a clock edge: reset wins and `o` = 0.
  - Reset asserted mid-operation: `o` goes to 0 at once, and the previously computed value is discarded.
- Back-to-back input changes on every cycle are fully supported. There is no handshake and no stall.

## Test plan
- Reset: hold `rst_n`=0 with `a`,`b`,`c`,`d` all 1 and toggle `clk` -> `o`=0 throughout. Release reset -> `o`=1 after the first edge.
- Exhaustive sweep: apply indices 0 to 15 in ascending order, one per cycle -> `o` sequence one cycle later is 0,1,0,0,0,1,0,0,0,1,0,0,1,1,1,1.
- Latency check: apply `a`=0, `b`=0, `c`=0, `d`=1 between edges -> `o` stays at its old value until the next rising edge, then becomes 1.
- Term isolation:
  - `a`=1, `b`=1, `c`=1, `d`=0 -> `o`=1, from the AND term only.
  - `a`=0, `b`=1, `c`=1, `d`=1 -> `o`=0.
- Mid-run reset: during the sweep at index 13 (`o`=1), pulse `rst_n` low between edges -> `o` drops to 0 asynchronously. After release, the next edge restores `o` from the current index.
- Parameter override: `TRUTH_TABLE`=16'h8000 -> `o`=1 only for index 15 (`a`=`b`=`c`=`d`=1), and 0 for the other 15 indices.
